// File: rtl/byp_cmd_credit_tracker_pkg.sv
// Shared types and default sizing for the bypass command credit tracker.
package byp_cmd_credit_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } byp_state_e;

    localparam int BYP_CMD_BITS_DEF        = 96;
    localparam int BYP_STS_BITS_DEF        = 32;
    localparam int BYP_MAX_OUTSTANDING_DEF = 8;
    localparam int BYP_TIMEOUT_CYCLES_DEF  = 65535;

endpackage

// File: rtl/byp_axis_reg.sv
// Single-stage valid/ready output register; s_en lets the owner withhold tready.
module byp_axis_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_en,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready
);

    // rst_n in the ready term keeps the upstream stalled while reset is held
    assign s_tready = rst_n && s_en && (!m_tvalid || m_tready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_tvalid <= 1'b0;
        end else if (s_tvalid && s_tready) begin
            m_tvalid <= 1'b1;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (s_tvalid && s_tready) begin
            m_tdata <= s_tdata;
        end
    end

endmodule

// File: rtl/byp_cmd_credit_tracker.sv
// Credit-limited bypass command/status forwarder with outstanding counter.
// Optional watchdog enabled by defining BYP_TIMEOUT_EN.
module byp_cmd_credit_tracker
    import byp_cmd_credit_tracker_pkg::*;
#(
    parameter int CMD_BITS        = BYP_CMD_BITS_DEF,
    parameter int STS_BITS        = BYP_STS_BITS_DEF,
    parameter int MAX_OUTSTANDING = BYP_MAX_OUTSTANDING_DEF,
    parameter int TIMEOUT_CYCLES  = BYP_TIMEOUT_CYCLES_DEF,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [CMD_BITS-1:0] s_cmd_tdata,
    input  logic                s_cmd_tvalid,
    output logic                s_cmd_tready,
    output logic [CMD_BITS-1:0] m_cmd_tdata,
    output logic                m_cmd_tvalid,
    input  logic                m_cmd_tready,
    input  logic [STS_BITS-1:0] s_sts_tdata,
    input  logic                s_sts_tvalid,
    output logic                s_sts_tready,
    output logic [STS_BITS-1:0] m_sts_tdata,
    output logic                m_sts_tvalid,
    input  logic                m_sts_tready,
    output logic [CNT_W-1:0]    outstanding,
    output logic                sts_underflow,
    output logic                timeout_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    byp_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_hs, sts_hs, inc, dec, unf_q;

    byp_axis_reg #(.W(CMD_BITS)) u_cmd_reg (
        .clk      (aclk),
        .rst_n    (aresetn),
        .s_en     (state_q != FULL),
        .s_tdata  (s_cmd_tdata),
        .s_tvalid (s_cmd_tvalid),
        .s_tready (s_cmd_tready),
        .m_tdata  (m_cmd_tdata),
        .m_tvalid (m_cmd_tvalid),
        .m_tready (m_cmd_tready)
    );

    byp_axis_reg #(.W(STS_BITS)) u_sts_reg (
        .clk      (aclk),
        .rst_n    (aresetn),
        .s_en     (1'b1),
        .s_tdata  (s_sts_tdata),
        .s_tvalid (s_sts_tvalid),
        .s_tready (s_sts_tready),
        .m_tdata  (m_sts_tdata),
        .m_tvalid (m_sts_tvalid),
        .m_tready (m_sts_tready)
    );

    assign cmd_hs = s_cmd_tvalid && s_cmd_tready;
    assign sts_hs = s_sts_tvalid && s_sts_tready;

    // A status seen at zero credits is forwarded but never consumes a count
    assign inc = cmd_hs && !(sts_hs && (cnt_q != '0));
    assign dec = sts_hs && !cmd_hs && (cnt_q != '0);

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (inc) cnt_d = cnt_q + CNT_W'(1);
        if (dec) cnt_d = cnt_q - CNT_W'(1);
        case (state_q)
            IDLE: begin
                if (inc) state_d = (MAX_OUTSTANDING == 1) ? FULL : ACTIVE;
            end
            ACTIVE: begin
                if (inc && cnt_q == MAX_CNT - CNT_W'(1)) state_d = FULL;
                else if (dec && cnt_q == CNT_W'(1))      state_d = IDLE;
            end
            FULL: begin
                if (dec) state_d = (MAX_OUTSTANDING == 1) ? IDLE : ACTIVE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (sts_hs && cnt_q == '0) unf_q <= 1'b1;
        end
    end

    assign outstanding   = cnt_q;
    assign sts_underflow = unf_q;

`ifdef BYP_TIMEOUT_EN
    localparam int              WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q;

    always_comb begin
        wd_d = wd_q;
        if (cnt_q == '0 || sts_hs) wd_d = '0;
        else if (wd_q != WD_MAX)   wd_d = wd_q + WD_W'(1);
    end

    // Flag rises on the same edge the counter reaches its limit
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (wd_d == WD_MAX) to_q <= 1'b1;
        end
    end

    assign timeout_err = to_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_byp_cmd_credit_tracker.sv
// Directed bench for byp_cmd_credit_tracker (MAX_OUTSTANDING=4, TIMEOUT_CYCLES=16).
module tb_byp_cmd_credit_tracker;

    localparam int CMD_BITS = 96;
    localparam int STS_BITS = 32;
    localparam int MAXO     = 4;
    localparam int TO       = 16;
    localparam int CNT_W    = $clog2(MAXO + 1);

    logic                aclk = 1'b0;
    logic                aresetn;
    logic [CMD_BITS-1:0] s_cmd_tdata, m_cmd_tdata;
    logic                s_cmd_tvalid, s_cmd_tready, m_cmd_tvalid, m_cmd_tready;
    logic [STS_BITS-1:0] s_sts_tdata, m_sts_tdata;
    logic                s_sts_tvalid, s_sts_tready, m_sts_tvalid, m_sts_tready;
    logic [CNT_W-1:0]    outstanding;
    logic                sts_underflow, timeout_err;

    int checks = 0;
    int errors = 0;
    logic exp_to;

    byp_cmd_credit_tracker #(
        .CMD_BITS(CMD_BITS), .STS_BITS(STS_BITS),
        .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_cmd_tdata(s_cmd_tdata), .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready),
        .m_cmd_tdata(m_cmd_tdata), .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tready(m_cmd_tready),
        .s_sts_tdata(s_sts_tdata), .s_sts_tvalid(s_sts_tvalid), .s_sts_tready(s_sts_tready),
        .m_sts_tdata(m_sts_tdata), .m_sts_tvalid(m_sts_tvalid), .m_sts_tready(m_sts_tready),
        .outstanding(outstanding), .sts_underflow(sts_underflow), .timeout_err(timeout_err)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        aresetn = 1'b0;
        s_cmd_tdata = '0; s_cmd_tvalid = 1'b0; m_cmd_tready = 1'b1;
        s_sts_tdata = '0; s_sts_tvalid = 1'b0; m_sts_tready = 1'b1;
        tick(); tick();
        chk("rst_cmd_tready", s_cmd_tready, 0);
        chk("rst_sts_tready", s_sts_tready, 0);
        chk("rst_m_cmd_tvalid", m_cmd_tvalid, 0);
        chk("rst_m_sts_tvalid", m_sts_tvalid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_underflow", sts_underflow, 0);
        chk("rst_timeout", timeout_err, 0);
        aresetn = 1'b1;
        tick();

        // four back-to-back commands fill the credits
        for (int i = 0; i < 4; i++) begin
            s_cmd_tvalid = 1'b1;
            s_cmd_tdata  = CMD_BITS'(96'h100 + i);
            chk("fill_tready", s_cmd_tready, 1);
            tick();
            chk("fill_m_valid", m_cmd_tvalid, 1);
            chk("fill_m_data", m_cmd_tdata, 128'h100 + i);
            chk("fill_outstanding", outstanding, i + 1);
        end
        s_cmd_tdata = CMD_BITS'(96'h200);
        chk("full_tready", s_cmd_tready, 0);
        tick();
        chk("full_no_new", m_cmd_tvalid, 0);
        chk("full_outstanding", outstanding, 4);
        chk("full_tready_hold", s_cmd_tready, 0);
        s_cmd_tvalid = 1'b0;

        // one status releases one credit
        s_sts_tvalid = 1'b1; s_sts_tdata = 32'h5001;
        tick();
        s_sts_tvalid = 1'b0;
        chk("sts1_valid", m_sts_tvalid, 1);
        chk("sts1_data", m_sts_tdata, 32'h5001);
        chk("sts1_outstanding", outstanding, 3);
        chk("sts1_cmd_tready", s_cmd_tready, 1);

        s_sts_tvalid = 1'b1; s_sts_tdata = 32'h5002;
        tick();
        chk("sts2_outstanding", outstanding, 2);

        // simultaneous command and status
        s_cmd_tvalid = 1'b1; s_cmd_tdata = CMD_BITS'(96'h300);
        s_sts_tdata = 32'h5003;
        tick();
        s_cmd_tvalid = 1'b0;
        chk("both_outstanding", outstanding, 2);
        chk("both_cmd_valid", m_cmd_tvalid, 1);
        chk("both_cmd_data", m_cmd_tdata, 128'h300);
        chk("both_sts_valid", m_sts_tvalid, 1);
        chk("both_sts_data", m_sts_tdata, 32'h5003);

        s_sts_tdata = 32'h5004; tick();
        s_sts_tdata = 32'h5005; tick();
        chk("drain_outstanding", outstanding, 0);
        chk("drain_underflow", sts_underflow, 0);

        // status with no credits outstanding
        s_sts_tdata = 32'h5006;
        tick();
        s_sts_tvalid = 1'b0;
        chk("unf_sts_valid", m_sts_tvalid, 1);
        chk("unf_sts_data", m_sts_tdata, 32'h5006);
        chk("unf_outstanding", outstanding, 0);
        chk("unf_flag", sts_underflow, 1);
        tick(); tick();
        chk("unf_sticky", sts_underflow, 1);
        chk("unf_outstanding2", outstanding, 0);

        // backpressure holds 0xABC stable
        m_cmd_tready = 1'b0;
        s_cmd_tvalid = 1'b1; s_cmd_tdata = CMD_BITS'(96'hABC);
        tick();
        s_cmd_tdata = CMD_BITS'(96'hDEF);
        for (int i = 0; i < 5; i++) begin
            chk("bp_tready", s_cmd_tready, 0);
            chk("bp_valid", m_cmd_tvalid, 1);
            chk("bp_data", m_cmd_tdata, 128'hABC);
            tick();
        end
        s_cmd_tvalid = 1'b0;
        m_cmd_tready = 1'b1;
        chk("bp_release_valid", m_cmd_tvalid, 1);
        tick();
        chk("bp_one_xfer", m_cmd_tvalid, 0);
        chk("bp_outstanding", outstanding, 1);

        s_sts_tvalid = 1'b1; s_sts_tdata = 32'h5007;
        tick();
        s_sts_tvalid = 1'b0;
        chk("bp_drain", outstanding, 0);

        // watchdog: one command, status withheld
`ifdef BYP_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        s_cmd_tvalid = 1'b1; s_cmd_tdata = CMD_BITS'(96'h77);
        tick();
        s_cmd_tvalid = 1'b0;
        for (int i = 0; i < TO - 1; i++) tick();
        chk("wd_before_limit", timeout_err, 0);
        tick();
        chk("wd_at_limit", timeout_err, exp_to);
        s_sts_tvalid = 1'b1; s_sts_tdata = 32'h5008;
        tick();
        s_sts_tvalid = 1'b0;
        chk("wd_after_sts_outstanding", outstanding, 0);
        tick(); tick();
        chk("wd_sticky", timeout_err, exp_to);
        aresetn = 1'b0;
        tick();
        chk("wd_reset_clear", timeout_err, 0);
        chk("wd_reset_underflow", sts_underflow, 0);
        chk("wd_reset_outstanding", outstanding, 0);
        aresetn = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
